// File: rtl/etb_pkg.sv
// Shared register map, configuration layout and channel state encoding
// for the event trigger router.
package etb_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_SWTRIG   = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h08;
  localparam logic [7:0] ADDR_CFG_BASE = 8'h10;

  localparam int CTRL_GEN_BIT   = 0;
  localparam int CTRL_OVIE_BIT  = 1;
  localparam int STATUS_OVF_LSB = 8;

  localparam int CFG_SRC_LSB   = 0;
  localparam int CFG_DST_LSB   = 4;
  localparam int CFG_ACT_BIT   = 8;
  localparam int CFG_DELAY_LSB = 16;
  localparam int CFG_CHEN_BIT  = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic       chen;
    logic [7:0] delay;
    logic       act;
    logic [1:0] dst;
    logic [1:0] src;
  } ch_cfg_t;

  function automatic ch_cfg_t unpack_cfg(input logic [31:0] word);
    ch_cfg_t c;
    c.src   = word[CFG_SRC_LSB +: 2];
    c.dst   = word[CFG_DST_LSB +: 2];
    c.act   = word[CFG_ACT_BIT];
    c.delay = word[CFG_DELAY_LSB +: 8];
    c.chen  = word[CFG_CHEN_BIT];
    return c;
  endfunction

  function automatic logic [31:0] pack_cfg(input ch_cfg_t c);
    logic [31:0] word;
    word                     = '0;
    word[CFG_SRC_LSB +: 2]   = c.src;
    word[CFG_DST_LSB +: 2]   = c.dst;
    word[CFG_ACT_BIT]        = c.act;
    word[CFG_DELAY_LSB +: 8] = c.delay;
    word[CFG_CHEN_BIT]       = c.chen;
    return word;
  endfunction

endpackage

// File: rtl/etb_trig_router_if.sv
// Zero-wait-state APB slave bundle used to program the trigger router.
interface etb_trig_router_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/etb_trig_chan.sv
// One routing channel: trigger acceptance, optional delay countdown and a
// single FIRE cycle carrying the destination/action latched at trigger time.
module etb_trig_chan
  import etb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig,
  input  logic       run,
  input  logic [1:0] cfg_dst,
  input  logic       cfg_act,
  input  logic [7:0] cfg_delay,
  output logic       fire,
  output logic [1:0] fire_dst,
  output logic       fire_act,
  output logic       busy,
  output logic       ovf_set
);

  ch_state_e  state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] dst_q, dst_nxt;
  logic       act_q, act_nxt;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dst_q <= '0;
      act_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dst_q <= dst_nxt;
      act_q <= act_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dst_nxt   = dst_q;
    act_nxt   = act_q;
    ovf_set   = 1'b0;
    unique case (state)
      IDLE, FIRE: begin
        if (trig) begin
          dst_nxt = cfg_dst;
          act_nxt = cfg_act;
          if (cfg_delay == 8'd0) begin
            state_nxt = FIRE;
          end else begin
            cnt_nxt   = cfg_delay;
            state_nxt = COUNT;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      COUNT: begin
        // Losing GEN or CHEN drops the pending trigger without a pulse.
        if (!run) begin
          state_nxt = IDLE;
        end else begin
          ovf_set = trig;
          if (cnt == 8'd1) begin
            state_nxt = FIRE;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fire     = (state == FIRE);
  assign busy     = (state == COUNT);
  assign fire_dst = dst_q;
  assign fire_act = act_q;

endmodule

// File: rtl/etb_trig_router.sv
// Event trigger router: APB register file, source edge detection, four
// delayed routing channels and the merged en_on/en_off destination pulses.
module etb_trig_router
  import etb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int NUM_DST = 4,
  parameter int NUM_CH  = 4
) (
  input  logic                pclk,
  input  logic                presetn,
  etb_trig_router_if.slave    apb,
  input  logic [NUM_SRC-1:0]  src_trig,
  output logic [NUM_DST-1:0]  dst_trig_en_on,
  output logic [NUM_DST-1:0]  dst_trig_en_off,
  output logic                etb_intr
);

  logic              gen;
  logic              ovie;
  ch_cfg_t           cfg [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [NUM_SRC-1:0] src_d;

  logic [7:0]        addr_w;
  logic              wr_en;
  logic              cfg_hit;
  logic [1:0]        cfg_idx;
  logic [NUM_CH-1:0] swtrig;
  logic [NUM_CH-1:0] ovf_clr;
  logic [3:0]        edge_pad;
  logic [NUM_CH-1:0] trig;
  logic [31:0]       rdata;

  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] fire_act;
  logic [1:0]        fire_dst [NUM_CH];
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] ovf_set;

  logic unused_bits;
  assign unused_bits = ^{apb.pwdata[7:6], apb.pwdata[15:12], apb.pwdata[30:24]};

  assign addr_w  = apb.paddr & 8'hFC;
  assign wr_en   = apb.psel & apb.penable & apb.pwrite;
  assign cfg_idx = addr_w[3:2];
  assign cfg_hit = (addr_w[7:4] == ADDR_CFG_BASE[7:4]) && (int'(cfg_idx) < NUM_CH);
  assign swtrig  = (wr_en && addr_w == ADDR_SWTRIG) ? apb.pwdata[NUM_CH-1:0] : '0;
  assign ovf_clr = (wr_en && addr_w == ADDR_STATUS) ? apb.pwdata[STATUS_OVF_LSB +: NUM_CH] : '0;

  always_comb begin
    edge_pad              = '0;
    edge_pad[NUM_SRC-1:0] = src_trig & ~src_d;
  end

  // HW edge and SW trigger OR together, so coincident ones count once.
  always_comb begin
    trig = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      trig[k] = gen & cfg[k].chen &
                (((int'(cfg[k].src) < NUM_SRC) & edge_pad[cfg[k].src]) | swtrig[k]);
    end
  end

  // NOTE: the config file is reset like any register so it reads back 0 after reset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      gen      <= 1'b0;
      ovie     <= 1'b0;
      ovf      <= '0;
      src_d    <= '0;
      etb_intr <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) cfg[k] <= '0;
    end else begin
      src_d    <= src_trig;
      ovf      <= (ovf & ~ovf_clr) | ovf_set;
      etb_intr <= ovie & (|ovf);
      if (wr_en && addr_w == ADDR_CTRL) begin
        gen  <= apb.pwdata[CTRL_GEN_BIT];
        ovie <= apb.pwdata[CTRL_OVIE_BIT];
      end
      if (wr_en && cfg_hit) cfg[cfg_idx] <= unpack_cfg(apb.pwdata);
    end
  end

  always_comb begin
    rdata = '0;
    if (apb.psel && !apb.pwrite) begin
      if (addr_w == ADDR_CTRL) begin
        rdata[CTRL_GEN_BIT]  = gen;
        rdata[CTRL_OVIE_BIT] = ovie;
      end else if (addr_w == ADDR_STATUS) begin
        rdata[NUM_CH-1:0]              = busy;
        rdata[STATUS_OVF_LSB +: NUM_CH] = ovf;
      end else if (cfg_hit) begin
        rdata = pack_cfg(cfg[cfg_idx]);
      end
    end
  end
  assign apb.prdata = rdata;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    etb_trig_chan u_chan (
      .clk       (pclk),
      .rst_n     (presetn),
      .trig      (trig[k]),
      .run       (gen & cfg[k].chen),
      .cfg_dst   (cfg[k].dst),
      .cfg_act   (cfg[k].act),
      .cfg_delay (cfg[k].delay),
      .fire      (fire[k]),
      .fire_dst  (fire_dst[k]),
      .fire_act  (fire_act[k]),
      .busy      (busy[k]),
      .ovf_set   (ovf_set[k])
    );
  end

  // Driven only from channel state flops; channels sharing a target merge.
  always_comb begin
    dst_trig_en_on  = '0;
    dst_trig_en_off = '0;
    for (int d = 0; d < NUM_DST; d++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (fire[k] && fire_dst[k] == 2'(d)) begin
          if (fire_act[k]) dst_trig_en_off[d] = 1'b1;
          else             dst_trig_en_on[d]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_etb_trig_router.sv
// Directed bench for etb_trig_router: register reset, routing latency,
// delay/busy, overflow and interrupt, merging, abort and mid-count reset.
module tb_etb_trig_router;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [3:0] src_trig;
  logic [3:0] en_on;
  logic [3:0] en_off;
  logic       etb_intr;
  logic [31:0] rd;

  int checks   = 0;
  int failures = 0;

  etb_trig_router_if apb ();

  etb_trig_router #(.NUM_SRC(4), .NUM_DST(4), .NUM_CH(4)) dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .apb             (apb.slave),
    .src_trig        (src_trig),
    .dst_trig_en_on  (en_on),
    .dst_trig_en_off (en_off),
    .etb_intr        (etb_intr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge pclk);
  endtask

  // Called at a negedge; commit happens on the posedge closing the access phase.
  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
    apb.paddr = addr; apb.pwdata = data;
    tick();
    apb.penable = 1'b1;
    tick();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = addr;
    tick();
    apb.penable = 1'b1;
    #1 data = apb.prdata;
    tick();
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // Samples a register within the current cycle without crossing a clock edge.
  task automatic peek(input logic [7:0] addr, output logic [31:0] data);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = addr;
    #1 data = apb.prdata;
    apb.psel = 1'b0;
  endtask

  initial begin
    logic [7:0] addrs [7];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C};
    presetn = 1'b0; src_trig = '0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    tick(3);
    presetn = 1'b1;
    tick();

    // Reset state
    check("rst_en_on", 32'(en_on), 32'h0);
    check("rst_en_off", 32'(en_off), 32'h0);
    check("rst_intr", 32'(etb_intr), 32'h0);
    check("rst_prdata_idle", apb.prdata, 32'h0);
    for (int i = 0; i < 7; i++) begin
      apb_read(addrs[i], rd);
      check($sformatf("rst_reg_%02h", addrs[i]), rd, 32'h0);
    end

    // CH0: SRC0 -> DST1 en_on, no delay; GEN still 0 so nothing fires
    apb_write(8'h10, 32'h8000_0010);
    apb_read(8'h10, rd);
    check("ch0_cfg_rb", rd, 32'h8000_0010);
    src_trig[0] = 1'b1;
    tick();
    src_trig[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("gen0_no_pulse", 32'({en_off, en_on}), 32'h0);
      tick();
    end

    apb_write(8'h00, 32'h1);
    apb_read(8'h00, rd);
    check("ctrl_rb", rd, 32'h1);

    // Held-high source fires exactly once, in T+1
    src_trig[0] = 1'b1;
    tick();
    check("ch0_pulse_t1", 32'(en_on), 32'h2);
    check("ch0_off_t1", 32'(en_off), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("ch0_held_no_repeat", 32'({en_off, en_on}), 32'h0);
    end
    src_trig[0] = 1'b0;

    // CH1: SRC1 -> DST0 en_off, DELAY=10
    apb_write(8'h14, 32'h800A_0101);
    tick();
    src_trig[1] = 1'b1;
    tick();
    src_trig[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      peek(8'h08, rd);
      check($sformatf("ch1_busy_t%0d", i), rd, 32'h2);
      check($sformatf("ch1_nopulse_t%0d", i), 32'({en_off, en_on}), 32'h0);
      tick();
    end
    check("ch1_pulse_t11", 32'(en_off), 32'h1);
    check("ch1_on_t11", 32'(en_on), 32'h0);
    peek(8'h08, rd);
    check("ch1_busy_t11", rd, 32'h0);
    tick();
    check("ch1_pulse_t12", 32'(en_off), 32'h0);

    // Second edge during COUNT: one pulse, OVF[1] set
    tick();
    src_trig[1] = 1'b1;
    tick();
    src_trig[1] = 1'b0;
    tick(4);
    src_trig[1] = 1'b1;
    tick();
    src_trig[1] = 1'b0;
    tick(5);
    check("ovf_pulse_t11", 32'(en_off), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ovf_single_pulse", 32'({en_off, en_on}), 32'h0);
    end
    apb_read(8'h08, rd);
    check("ovf_status", rd, 32'h200);
    check("ovf_intr_masked", 32'(etb_intr), 32'h0);
    apb_write(8'h00, 32'h3);
    tick();
    check("ovf_intr_set", 32'(etb_intr), 32'h1);
    apb_write(8'h08, 32'h100);
    tick();
    apb_read(8'h08, rd);
    check("w1c_other_bit", rd, 32'h200);
    apb_write(8'h08, 32'h200);
    tick();
    check("ovf_intr_clr", 32'(etb_intr), 32'h0);
    apb_read(8'h08, rd);
    check("ovf_status_clr", rd, 32'h0);

    // CH2/CH3 both -> DST2 en_on: merged pulse via SWTRIG
    apb_write(8'h18, 32'h8000_0022);
    apb_write(8'h1C, 32'h8000_0023);
    apb_write(8'h04, 32'hC);
    check("merge_pulse", 32'(en_on), 32'h4);
    check("merge_off", 32'(en_off), 32'h0);
    tick();
    check("merge_single", 32'({en_off, en_on}), 32'h0);

    // SW trigger and HW edge on CH2 in the same cycle
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
    apb.paddr = 8'h04; apb.pwdata = 32'h4;
    tick();
    apb.penable = 1'b1;
    src_trig[2] = 1'b1;
    tick();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    src_trig[2] = 1'b0;
    check("swhw_pulse", 32'(en_on), 32'h4);
    tick();
    check("swhw_single", 32'({en_off, en_on}), 32'h0);
    apb_read(8'h08, rd);
    check("swhw_no_ovf", rd, 32'h0);

    // CH0 DELAY=20, abort by clearing CHEN mid-count
    apb_write(8'h10, 32'h8014_0010);
    tick();
    src_trig[0] = 1'b1;
    tick();
    src_trig[0] = 1'b0;
    tick(3);
    peek(8'h08, rd);
    check("abort_busy_before", rd, 32'h1);
    apb_write(8'h10, 32'h0014_0010);
    tick();
    peek(8'h08, rd);
    check("abort_busy_after", rd, 32'h0);
    for (int i = 0; i < 25; i++) begin
      tick();
      check("abort_no_pulse", 32'({en_off, en_on}), 32'h0);
    end

    // Reset asserted mid-count
    apb_write(8'h10, 32'h8014_0010);
    tick();
    src_trig[0] = 1'b1;
    tick();
    src_trig[0] = 1'b0;
    tick(3);
    peek(8'h08, rd);
    check("rstmid_busy_before", rd, 32'h1);
    presetn = 1'b0;
    #1;
    check("rstmid_outputs", 32'({etb_intr, en_off, en_on}), 32'h0);
    peek(8'h08, rd);
    check("rstmid_status", rd, 32'h0);
    tick(2);
    presetn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("rstmid_no_pulse", 32'({en_off, en_on}), 32'h0);
    end
    apb_read(8'h10, rd);
    check("rstmid_cfg_cleared", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
